dlfloat_mac_seq: RTL and testbench
==================================

Name: dlfloat_mac_seq

Overview:
- Sequencer for the 16-bit DLFloat MAC core: 1 sign, 6 exponent and 9 mantissa bits; the MAC operand is {msb byte, lsb byte}.
- Collects byte-lane operand beats from the chip pins and pairs them as A/B.
- Issues each pair to the MAC with an accumulator-clear at vector start, drains the MAC pipeline, and presents the dot-product result through a valid/ready output.
- Sits between the pin wrapper and the MAC core; replaces free-running pin-driven sequencing.

Parameters:
- MAC_LAT, 2, cycles from mac_en to mac_result reflecting that product (1..7)
- LEN_W, 8, width of the vector-length field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a vector op; sampled only in IDLE
- abort  in  1  synchronous cancel, return to IDLE
- vec_len  in  LEN_W  number of A/B pairs; captured on start
- in_msb  in  8  operand high byte (sign, exponent, mantissa[8])
- in_lsb  in  8  operand low byte (mantissa[7:0])
- in_valid  in  1  operand beat present
- in_ready  out  1  sequencer accepts a beat this cycle
- mac_a  out  16  registered operand A to MAC
- mac_b  out  16  registered operand B to MAC
- mac_en  out  1  one-cycle issue strobe
- mac_acc_clr  out  1  one-cycle accumulator clear
- mac_result  in  16  MAC accumulator output
- res_data  out  16  captured dot-product result
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_special  out  1  res_data exponent == 6'h3F (inf/NaN class)
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: state IDLE, all outputs 0, pair counter 0, drain counter 0.
- States: IDLE, LOAD_A, LOAD_B, DRAIN, OUTPUT.
- A beat transfers when in_valid && in_ready. in_ready=1 only in LOAD_A/LOAD_B.
- IDLE:
  - start && vec_len!=0: capture vec_len, pulse mac_acc_clr next cycle, go LOAD_A.
  - start && vec_len==0: res_data=16'h0000, res_valid=1, go OUTPUT; no MAC activity.
- LOAD_A: on transfer, A_reg <= {in_msb,in_lsb}, go LOAD_B. No transfer means stay (stall, no timeout).
- LOAD_B:
  - On transfer, mac_b <= beat, mac_a <= A_reg, mac_en=1 the following cycle, count++.
  - If count == vec_len-1, go DRAIN, else go LOAD_A.
- Throughput: 1 pair per 2 cycles with in_valid held high. mac_en overlaps the next LOAD_A cycle.
- mac_acc_clr is asserted the cycle after start acceptance, so it always precedes the first mac_en by ≥1 cycle.
- DRAIN:
  - Counter loads MAC_LAT on the last mac_en cycle and decrements each cycle.
  - At 0, res_data <= mac_result, res_special set from mac_result[14:9]==6'h3F, res_valid=1, go OUTPUT.
  - res_valid rises exactly MAC_LAT+1 cycles after the last mac_en.
- OUTPUT: hold res_data/res_valid stable until res_ready. On res_valid&&res_ready, res_valid=0 next cycle, go IDLE. The earliest next start is accepted the cycle after.
- start while busy is ignored. vec_len changes after capture have no effect.
- abort:
  - Any state returns to IDLE next cycle; res_valid and in_ready are cleared.
  - A mac_en already scheduled for that cycle still fires. No further mac_en is issued.
  - abort has priority over start, transfers and res_ready in the same cycle.
- rst mid-operation is identical to abort, plus res_data, mac_a and mac_b are cleared.
- The counter is LEN_W bits. vec_len = 2^LEN_W-1 is valid; no wrap occurs because the compare is against vec_len-1.
- No arithmetic on operand values. The sequencer is value-agnostic (zero, subnormal and inf operands pass through unchanged).

Decomposition:
- Shared package dlfloat_pkg holds:
  - constants DLF_W=16, EXP_W=6, MAN_W=9, EXP_SPECIAL=6'h3F
  - typedef dlfloat_t (16-bit packed: sign, exp, man)
  - state enum seq_state_t
- One sub-module, dlfloat_beat_pack: pairs byte lanes into dlfloat_t and flags special exponent. Reused for the res_special decode.

Test Plan (bench uses a stub MAC: mac_result = registered XOR-accumulate of a^b, latency MAC_LAT):
- start, vec_len=1, beats 0x3EA3 then 0x4073:
  - mac_acc_clr pulses first.
  - mac_en once, with mac_a=0x3EA3 and mac_b=0x4073.
  - res_valid rises MAC_LAT+1 cycles after mac_en, with res_data = stub value 0x7ED0.
- vec_len=3 with in_valid high continuously: mac_en pulses every 2 cycles exactly 3 times, then 1 result.
- in_valid toggled 1-of-3 cycles during vec_len=2: order preserved (A,B,A,B), no extra mac_en, in_ready low in DRAIN/OUTPUT.
- res_ready held low 5 cycles: res_data stable. start pulsed during OUTPUT is ignored. Release gives IDLE the next cycle.
- abort asserted in LOAD_B together with a transfer: no mac_en after the abort cycle, busy=0 next cycle, res_valid never rises. A following start with vec_len=1 completes normally.
- Specials and edge cases:
  - vec_len=0: res_valid the cycle after start with res_data=0x0000, no mac_en.
  - Stub forced to 0xFFFF: res_special=1.
  - rst in DRAIN: all outputs 0 next cycle.

Source files
------------

// File: rtl/dlfloat_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dlfloat_pkg
// Brief    : Shared DLFloat16 types, field widths and sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dlfloat_pkg;

    localparam int DLF_W = 16;
    localparam int EXP_W = 6;
    localparam int MAN_W = 9;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 6'h3F;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } dlfloat_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4
    } seq_state_t;

    // All-ones exponent marks the inf/NaN class.
    function automatic logic is_special(input dlfloat_t v);
        return v.exp == EXP_SPECIAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlfloat_beat_pack.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_beat_pack
// Brief    : Joins a high/low byte pair into a DLFloat16 word and flags the
//            inf/NaN exponent class.
// Revision : 1.0 - initial release
// ============================================================================
module dlfloat_beat_pack
    import dlfloat_pkg::*;
(
    input  logic [7:0] i_msb,
    input  logic [7:0] i_lsb,
    output dlfloat_t   o_word,
    output logic       o_special
);

    assign o_word    = dlfloat_t'({i_msb, i_lsb});
    assign o_special = is_special(o_word);

endmodule
`default_nettype wire

// File: rtl/dlfloat_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_mac_seq
// Brief    : Collects byte-lane A/B operand beats, issues them to the DLFloat
//            MAC, drains its pipeline and presents the dot product via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module dlfloat_mac_seq
    import dlfloat_pkg::*;
#(
    parameter int MAC_LAT = 2,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] vec_len,
    input  logic [7:0]       in_msb,
    input  logic [7:0]       in_lsb,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DLF_W-1:0] mac_a,
    output logic [DLF_W-1:0] mac_b,
    output logic             mac_en,
    output logic             mac_acc_clr,
    input  logic [DLF_W-1:0] mac_result,
    output logic [DLF_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_special,
    output logic             busy
);

    localparam int c_DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    seq_state_t             r_state;
    seq_state_t             w_state_next;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_count;
    logic [c_DRAIN_W-1:0]   r_drain;
    dlfloat_t               r_a_reg;

    logic                   w_xfer;
    logic                   w_last;
    logic                   w_drain_done;
    logic [7:0]             w_pack_msb;
    logic [7:0]             w_pack_lsb;
    dlfloat_t               w_pack;
    logic                   w_pack_special;

    // Operand lanes are idle while draining, so one packer serves both the
    // incoming beats and the result decode.
    assign w_pack_msb = (r_state == S_DRAIN) ? mac_result[15:8] : in_msb;
    assign w_pack_lsb = (r_state == S_DRAIN) ? mac_result[7:0]  : in_lsb;

    dlfloat_beat_pack u_pack (
        .i_msb     (w_pack_msb),
        .i_lsb     (w_pack_lsb),
        .o_word    (w_pack),
        .o_special (w_pack_special)
    );

    assign in_ready     = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign busy         = (r_state != S_IDLE);
    assign w_xfer       = in_valid && in_ready;
    assign w_last       = (r_count == (r_len - LEN_W'(1)));
    assign w_drain_done = (r_drain == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next = (vec_len != '0) ? S_LOAD_A : S_OUTPUT;
                    end
                end
                S_LOAD_A: begin
                    if (w_xfer) w_state_next = S_LOAD_B;
                end
                S_LOAD_B: begin
                    if (w_xfer) w_state_next = w_last ? S_DRAIN : S_LOAD_A;
                end
                S_DRAIN: begin
                    if (w_drain_done) w_state_next = S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (res_ready) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_count     <= '0;
            r_drain     <= '0;
            r_a_reg     <= '0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_en      <= 1'b0;
            mac_acc_clr <= 1'b0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            res_special <= 1'b0;
        end else begin
            mac_en      <= 1'b0;
            mac_acc_clr <= 1'b0;
            if (abort) begin
                // An issue strobe already on the bus this cycle is left alone.
                res_valid <= 1'b0;
                r_count   <= '0;
                r_drain   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (vec_len != '0) begin
                                r_len       <= vec_len;
                                r_count     <= '0;
                                mac_acc_clr <= 1'b1;
                            end else begin
                                res_data    <= '0;
                                res_special <= 1'b0;
                                res_valid   <= 1'b1;
                            end
                        end
                    end
                    S_LOAD_A: begin
                        if (w_xfer) r_a_reg <= w_pack;
                    end
                    S_LOAD_B: begin
                        if (w_xfer) begin
                            mac_a   <= r_a_reg;
                            mac_b   <= w_pack;
                            mac_en  <= 1'b1;
                            r_count <= r_count + LEN_W'(1);
                            // Counter is live in the last issue cycle, so the
                            // result is sampled exactly MAC_LAT cycles later.
                            if (w_last) r_drain <= c_DRAIN_W'(MAC_LAT);
                        end
                    end
                    S_DRAIN: begin
                        if (w_drain_done) begin
                            res_data    <= w_pack;
                            res_special <= w_pack_special;
                            res_valid   <= 1'b1;
                        end else begin
                            r_drain <= r_drain - c_DRAIN_W'(1);
                        end
                    end
                    S_OUTPUT: begin
                        if (res_ready) res_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_mac_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dlfloat_mac_seq
// Brief    : Scoreboard bench for dlfloat_mac_seq with an XOR-accumulate MAC stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dlfloat_mac_seq;

    localparam int MAC_LAT = 2;
    localparam int LEN_W   = 8;

    logic             clk = 1'b0;
    logic             rst, start, abort, in_valid, res_ready;
    logic [LEN_W-1:0] vec_len;
    logic [7:0]       in_msb, in_lsb;
    logic             in_ready, mac_en, mac_acc_clr, res_valid, res_special, busy;
    logic [15:0]      mac_a, mac_b, mac_result, res_data;

    always #5 clk = ~clk;

    dlfloat_mac_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_len(vec_len),
        .in_msb(in_msb), .in_lsb(in_lsb), .in_valid(in_valid), .in_ready(in_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_acc_clr(mac_acc_clr),
        .mac_result(mac_result), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .res_special(res_special), .busy(busy)
    );

    // Stub MAC: XOR-accumulate of a^b, visible MAC_LAT cycles after mac_en.
    logic        force_ff;
    logic [15:0] stub_acc, stub_next;
    logic [15:0] stub_dl [MAC_LAT];

    always_comb begin
        stub_next = stub_acc;
        if (mac_acc_clr)  stub_next = 16'h0000;
        else if (mac_en)  stub_next = stub_acc ^ mac_a ^ mac_b;
    end

    always @(posedge clk) begin
        if (rst) begin
            stub_acc <= 16'h0000;
            for (int i = 0; i < MAC_LAT; i++) stub_dl[i] <= 16'h0000;
        end else begin
            stub_acc   <= stub_next;
            stub_dl[0] <= stub_next;
            for (int i = 1; i < MAC_LAT; i++) stub_dl[i] <= stub_dl[i-1];
        end
    end

    assign mac_result = force_ff ? 16'hFFFF : stub_dl[MAC_LAT-1];

    // Observation of strobes, sampled shortly after each rising edge.
    int          cyc = 0, en_total = 0, rv_rises = 0, rv_rise_cyc = 0, clr_cyc = -1;
    int          en_cyc_q[$];
    logic [31:0] pair_q[$];
    logic        rv_prev = 1'b0;

    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (mac_en) begin
            en_total++;
            en_cyc_q.push_back(cyc);
            pair_q.push_back({mac_a, mac_b});
        end
        if (mac_acc_clr) clr_cyc = cyc;
        if (res_valid && !rv_prev) begin
            rv_rises++;
            rv_rise_cyc = cyc;
        end
        rv_prev = res_valid;
    end

    int          errors = 0, checks = 0;
    logic [15:0] beat_q[$];
    logic [15:0] exp_q[$];

    function automatic logic [15:0] model_dot();
        logic [15:0] acc;
        acc = 16'h0000;
        for (int i = 0; i + 1 < beat_q.size(); i += 2) acc ^= beat_q[i] ^ beat_q[i+1];
        return acc;
    endfunction

    function automatic int pair_mismatches();
        int bad;
        bad = 0;
        if (pair_q.size() != beat_q.size() / 2) bad++;
        else for (int i = 0; i < pair_q.size(); i++)
            if (pair_q[i] !== {beat_q[2*i], beat_q[2*i+1]}) bad++;
        return bad;
    endfunction

    task automatic clear_obs();
        en_cyc_q.delete();
        pair_q.delete();
        clr_cyc = -1;
    endtask

    task automatic start_op(input logic [LEN_W-1:0] len);
        @(negedge clk);
        start   = 1'b1;
        vec_len = len;
        @(negedge clk);
        start   = 1'b0;
        vec_len = LEN_W'($urandom);
    endtask

    task automatic drive_beats(input int period, output bit ok);
        int          idx, g;
        bit          x;
        logic [15:0] b;
        idx = 0;
        g   = 0;
        while (idx < beat_q.size() && g < 200) begin
            b        = beat_q[idx];
            in_msb   = b[15:8];
            in_lsb   = b[7:0];
            in_valid = ((g % period) == 0);
            x        = in_valid && in_ready;
            @(negedge clk);
            if (x) idx++;
            g++;
        end
        in_valid = 1'b0;
        ok = (idx == beat_q.size());
    endtask

    task automatic wait_result(output bit ok);
        int n;
        n = 0;
        while (!res_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = res_valid;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, mac_en, mac_acc_clr, res_valid, res_special, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {in_ready, mac_en, mac_acc_clr, res_valid, res_special, busy});
        end
        checks++;
        if ({mac_a, mac_b, res_data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mac_a, mac_b, res_data});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        int en0;
        logic [15:0] e;
        clear_obs();
        en0 = en_total;
        start_op(LEN_W'(1));
        checks++;
        if (mac_acc_clr !== 1'b1) begin
            errors++;
            $display("FAIL single_acc_clr: got %b expected 1", mac_acc_clr);
        end
        beat_q = '{16'h3EA3, 16'h4073};
        exp_q.push_back(model_dot());
        drive_beats(1, ok);
        wait_result(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout: res_valid=%b expected 1", res_valid);
        end
        checks++;
        if (en_total - en0 != 1) begin
            errors++;
            $display("FAIL single_en_count: got %0d expected 1", en_total - en0);
        end
        checks++;
        if (pair_mismatches() != 0) begin
            errors++;
            $display("FAIL single_pair: got %0d bad pairs expected 0", pair_mismatches());
        end
        checks++;
        if (en_cyc_q.size() == 0 || clr_cyc < 0 || clr_cyc >= en_cyc_q[0]) begin
            errors++;
            $display("FAIL single_clr_order: clr cycle %0d not before first mac_en", clr_cyc);
        end
        checks++;
        if (en_cyc_q.size() == 0 || rv_rise_cyc - en_cyc_q[$] != MAC_LAT + 1) begin
            errors++;
            $display("FAIL single_latency: got %0d expected %0d",
                     (en_cyc_q.size() == 0) ? -1 : rv_rise_cyc - en_cyc_q[$], MAC_LAT + 1);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL single_data: got %h but scoreboard empty", res_data);
        end else begin
            e = exp_q.pop_front();
            if (res_data !== e) begin
                errors++;
                $display("FAIL single_data: got %h expected %h", res_data, e);
            end
        end
        checks++;
        if (res_data !== 16'h7ED0) begin
            errors++;
            $display("FAIL single_data_const: got %h expected 7ed0", res_data);
        end
        checks++;
        if (res_special !== (e[14:9] == 6'h3F)) begin
            errors++;
            $display("FAIL single_special: got %b expected %b", res_special, e[14:9] == 6'h3F);
        end
        release_result();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: valid=%b busy=%b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_stream();
        bit ok;
        int en0;
        logic [15:0] e;
        clear_obs();
        en0 = en_total;
        start_op(LEN_W'(3));
        beat_q = '{16'h1234, 16'h0F0F, 16'h4100, 16'h3C00, 16'h0001, 16'h8200};
        exp_q.push_back(model_dot());
        drive_beats(1, ok);
        wait_result(ok);
        checks++;
        if (!ok || en_total - en0 != 3) begin
            errors++;
            $display("FAIL stream_en_count: got %0d expected 3 (valid=%b)", en_total - en0, res_valid);
        end
        checks++;
        if (en_cyc_q.size() != 3 || en_cyc_q[1] - en_cyc_q[0] != 2 || en_cyc_q[2] - en_cyc_q[1] != 2) begin
            errors++;
            $display("FAIL stream_spacing: got %0d strobes, expected 3 spaced by 2", en_cyc_q.size());
        end
        checks++;
        if (pair_mismatches() != 0) begin
            errors++;
            $display("FAIL stream_pairs: got %0d bad pairs expected 0", pair_mismatches());
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_data: got %h but scoreboard empty", res_data);
        end else begin
            e = exp_q.pop_front();
            if (res_data !== e || res_special !== (e[14:9] == 6'h3F)) begin
                errors++;
                $display("FAIL stream_data: got %h/%b expected %h/%b",
                         res_data, res_special, e, e[14:9] == 6'h3F);
            end
        end
        release_result();
    endtask

    task automatic test_stall();
        bit ok;
        int en0, n, bad;
        logic [15:0] e;
        clear_obs();
        en0 = en_total;
        start_op(LEN_W'(2));
        beat_q = '{16'h2A5C, 16'h7001, 16'h0003, 16'h41F0};
        exp_q.push_back(model_dot());
        drive_beats(3, ok);
        bad = 0;
        n   = 0;
        while (!res_valid && n < 60) begin
            if (in_ready) bad++;
            @(negedge clk);
            n++;
        end
        if (in_ready) bad++;
        checks++;
        if (!res_valid || bad != 0) begin
            errors++;
            $display("FAIL stall_in_ready: got %0d ready cycles expected 0 (valid=%b)", bad, res_valid);
        end
        checks++;
        if (en_total - en0 != 2 || pair_mismatches() != 0) begin
            errors++;
            $display("FAIL stall_order: got %0d strobes, %0d bad pairs, expected 2 and 0",
                     en_total - en0, pair_mismatches());
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stall_data: got %h but scoreboard empty", res_data);
        end else begin
            e = exp_q.pop_front();
            if (res_data !== e) begin
                errors++;
                $display("FAIL stall_data: got %h expected %h", res_data, e);
            end
        end
        release_result();
    endtask

    task automatic test_backpressure();
        bit ok;
        int rv0, unstable;
        logic [15:0] e, held;
        clear_obs();
        start_op(LEN_W'(1));
        beat_q = '{16'h5A5A, 16'h0101};
        exp_q.push_back(model_dot());
        drive_beats(1, ok);
        wait_result(ok);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL hold_data: got %h but scoreboard empty", res_data);
        end else begin
            e = exp_q.pop_front();
            if (!ok || res_data !== e) begin
                errors++;
                $display("FAIL hold_data: got %h expected %h", res_data, e);
            end
        end
        held     = res_data;
        rv0      = rv_rises;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            start   = (i == 2);
            vec_len = LEN_W'(0);
            @(negedge clk);
            if (res_data !== held || res_valid !== 1'b1) unstable++;
        end
        start = 1'b0;
        checks++;
        if (unstable != 0 || rv_rises != rv0) begin
            errors++;
            $display("FAIL hold_stable: got %0d unstable cycles, %0d new rises, expected 0 0",
                     unstable, rv_rises - rv0);
        end
        release_result();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: valid=%b busy=%b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_zero_len();
        int en0;
        logic [15:0] e;
        en0     = en_total;
        start   = 1'b1;
        vec_len = LEN_W'(0);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_valid: valid=%b busy=%b expected 1 1", res_valid, busy);
        end
        checks++;
        e = exp_q.pop_front();
        if (res_data !== e || res_special !== 1'b0) begin
            errors++;
            $display("FAIL zero_data: got %h/%b expected %h/0", res_data, res_special, e);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (en_total != en0) begin
            errors++;
            $display("FAIL zero_no_mac: got %0d strobes expected 0", en_total - en0);
        end
        release_result();
    endtask

    task automatic test_abort();
        bit ok;
        int en0, rv0;
        logic [15:0] e;
        clear_obs();
        en0 = en_total;
        rv0 = rv_rises;
        start_op(LEN_W'(2));
        beat_q = '{16'h1111, 16'h2222, 16'h3333};
        drive_beats(1, ok);
        checks++;
        if (!ok || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: in_ready=%b expected 1", in_ready);
        end
        in_msb   = 8'h44;
        in_lsb   = 8'h44;
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b valid=%b ready=%b expected 0 0 0",
                     busy, res_valid, in_ready);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (en_total - en0 != 1 || rv_rises != rv0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d strobes, %0d rises, expected 1 0",
                     en_total - en0, rv_rises - rv0);
        end
        clear_obs();
        start_op(LEN_W'(1));
        beat_q = '{16'h7C00, 16'h0200};
        exp_q.push_back(model_dot());
        drive_beats(1, ok);
        wait_result(ok);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL abort_recover: got %h but scoreboard empty", res_data);
        end else begin
            e = exp_q.pop_front();
            if (!ok || res_data !== e || res_special !== (e[14:9] == 6'h3F)) begin
                errors++;
                $display("FAIL abort_recover: got %h/%b expected %h/%b",
                         res_data, res_special, e, e[14:9] == 6'h3F);
            end
        end
        release_result();
    endtask

    task automatic test_special();
        bit ok;
        logic [15:0] e;
        force_ff = 1'b1;
        clear_obs();
        start_op(LEN_W'(1));
        beat_q = '{16'h0001, 16'h0002};
        exp_q.push_back(16'hFFFF);
        drive_beats(1, ok);
        wait_result(ok);
        checks++;
        e = exp_q.pop_front();
        if (!ok || res_data !== e || res_special !== 1'b1) begin
            errors++;
            $display("FAIL special_flag: got %h/%b expected %h/1", res_data, res_special, e);
        end
        release_result();
        force_ff = 1'b0;
    endtask

    task automatic test_rst_drain();
        bit ok;
        int rv0;
        clear_obs();
        start_op(LEN_W'(1));
        beat_q = '{16'h1234, 16'h4321};
        drive_beats(1, ok);
        checks++;
        if (!ok || mac_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: mac_en=%b busy=%b expected 1 1", mac_en, busy);
        end
        rv0 = rv_rises;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, mac_en, mac_acc_clr, res_valid, res_special, busy} !== 6'b0
            || {mac_a, mac_b, res_data} !== 48'h0) begin
            errors++;
            $display("FAIL rst_drain_outputs: flags %b data %h expected all 0",
                     {in_ready, mac_en, mac_acc_clr, res_valid, res_special, busy},
                     {mac_a, mac_b, res_data});
        end
        repeat (6) @(negedge clk);
        checks++;
        if (rv_rises != rv0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_drain_quiet: got %0d rises busy=%b expected 0 0", rv_rises - rv0, busy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        vec_len   = '0;
        in_msb    = 8'h00;
        in_lsb    = 8'h00;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        force_ff  = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_backpressure();
        test_zero_len();
        test_abort();
        test_special();
        test_rst_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
